// File: rtl/layer_frame_store_forward.sv
// Store-and-forward buffer for length-prefixed byte frames; releases only complete, well-formed frames.
// Optional macro FRAME_STORE_STATS_EN adds saturating committed/dropped frame counters.
module layer_frame_store_forward #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic        cfg_flush,
    output logic        stat_frame_committed,
    output logic        stat_frame_dropped,
    output logic [15:0] stat_committed_count,
    output logic [15:0] stat_dropped_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    localparam logic [1:0] W_LEN  = 2'd0;
    localparam logic [1:0] W_BODY = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;

    logic [8:0]    mem_q [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] wr_commit_q, wr_commit_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    rem_q, rem_d;
    logic          rdy_q;
    logic          commit_q, commit_d;
    logic          drop_q, drop_d;
    logic          m_vld_q, m_vld_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_last_q, m_last_d;
    logic          beat, full, store;

    assign beat = s_axis_tvalid & rdy_q;
    assign full = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

    // Write side: wr_ptr runs ahead speculatively, wr_commit only moves on a well-formed tlast.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        rem_d       = rem_q;
        store       = 1'b0;
        commit_d    = 1'b0;
        drop_d      = 1'b0;
        if (beat) begin
            case (state_q)
                W_LEN: begin
                    if (s_axis_tdata == 8'd0 || s_axis_tlast || full) begin
                        drop_d  = 1'b1;
                        state_d = s_axis_tlast ? W_LEN : W_DROP;
                    end else begin
                        store    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        rem_d    = s_axis_tdata;
                        state_d  = W_BODY;
                    end
                end
                W_BODY: begin
                    rem_d = rem_q - 1'b1;
                    if (full) begin
                        drop_d  = 1'b1;
                        state_d = s_axis_tlast ? W_LEN : W_DROP;
                    end else if (s_axis_tlast && rem_q == 8'd1) begin
                        store       = 1'b1;
                        wr_ptr_d    = wr_ptr_q + 1'b1;
                        wr_commit_d = wr_ptr_q + 1'b1;
                        commit_d    = 1'b1;
                        state_d     = W_LEN;
                    end else if (s_axis_tlast) begin
                        drop_d  = 1'b1;
                        state_d = W_LEN;
                    end else if (rem_q == 8'd1) begin
                        drop_d  = 1'b1;
                        state_d = W_DROP;
                    end else begin
                        store    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
                W_DROP: begin
                    if (s_axis_tlast) state_d = W_LEN;
                end
                default: state_d = W_LEN;
            endcase
        end
        if (drop_d) wr_ptr_d = wr_commit_q;
    end

    // Read side: output register refills whenever empty or being consumed.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        m_vld_d  = m_vld_q;
        m_data_d = m_data_q;
        m_last_d = m_last_q;
        if (!m_vld_q || m_axis_tready) begin
            if (rd_ptr_q != wr_commit_q) begin
                m_vld_d  = 1'b1;
                m_data_d = mem_q[rd_ptr_q[AW-1:0]][7:0];
                m_last_d = mem_q[rd_ptr_q[AW-1:0]][8];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else begin
                m_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= W_LEN;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            rdy_q       <= 1'b0;
            commit_q    <= 1'b0;
            drop_q      <= 1'b0;
            m_vld_q     <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
        end else if (cfg_flush) begin
            state_q     <= W_LEN;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            rem_q       <= '0;
            rdy_q       <= 1'b1;
            commit_q    <= 1'b0;
            drop_q      <= 1'b0;
            m_vld_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            rem_q       <= rem_d;
            rdy_q       <= 1'b1;
            commit_q    <= commit_d;
            drop_q      <= drop_d;
            m_vld_q     <= m_vld_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store && !cfg_flush) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

`ifdef FRAME_STORE_STATS_EN
    logic [15:0] ccnt_q, dcnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ccnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            if (commit_q && ccnt_q != 16'hFFFF) ccnt_q <= ccnt_q + 1'b1;
            if (drop_q && dcnt_q != 16'hFFFF)   dcnt_q <= dcnt_q + 1'b1;
        end
    end

    assign stat_committed_count = ccnt_q;
    assign stat_dropped_count   = dcnt_q;
`else
    assign stat_committed_count = 16'd0;
    assign stat_dropped_count   = 16'd0;
`endif

    assign s_axis_tready        = rdy_q;
    assign m_axis_tvalid        = m_vld_q;
    assign m_axis_tdata         = m_data_q;
    assign m_axis_tlast         = m_last_q;
    assign stat_frame_committed = commit_q;
    assign stat_frame_dropped   = drop_q;

endmodule

// File: tb/tb_layer_frame_store_forward.sv
// Scoreboard bench for layer_frame_store_forward: frame-level reference model, random and directed frames.
module tb_layer_frame_store_forward;

    localparam int DEPTH = 16;

    logic        clk, rst;
    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic        cfg_flush;
    logic        p_commit, p_drop;
    logic [15:0] c_commit, c_drop;

    layer_frame_store_forward #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .cfg_flush(cfg_flush),
        .stat_frame_committed(p_commit), .stat_frame_dropped(p_drop),
        .stat_committed_count(c_commit), .stat_dropped_count(c_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_commit = 0, exp_drop = 0;
    int cnt_commit = 0, cnt_drop = 0;
    int rmode = 1;
    logic [8:0] sb[$];
    logic [8:0] frm[$];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = 1'($urandom_range(1));
        endcase
    end

    // Monitor: pulse counting, output stability and scoreboard pops
    always @(negedge clk) begin
        if (rst || cfg_flush) begin
            prev_stall = 1'b0;
        end else begin
            if (p_commit) cnt_commit++;
            if (p_drop) cnt_drop++;
            if (prev_stall) begin
                chk("hold_word", {23'd0, m_tlast, m_tdata}, {23'd0, prev_word});
                chk("hold_valid", {31'd0, m_tvalid}, 32'd1);
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected actual=%0h required=none", {m_tlast, m_tdata});
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    chk("out_word", {23'd0, m_tlast, m_tdata}, {23'd0, e});
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_word  = {m_tlast, m_tdata};
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frm(input bit gaps);
        foreach (frm[i]) begin
            beat(frm[i][7:0], frm[i][8]);
            if (gaps && $urandom_range(3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic expect_frm();
        foreach (frm[i]) sb.push_back(frm[i]);
        exp_commit++;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            idle(1);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout remaining=%0d required=0", sb.size());
            sb.delete();
        end
        idle(4);
    endtask

    task automatic set_frm(input logic [7:0] b[$], input int last_idx);
        frm.delete();
        foreach (b[i]) frm.push_back({(i == last_idx), b[i]});
    endtask

    // Frame types: 0..5 legal, 6 short, 7 long, 8 zero length, 9 tlast on length byte
    task automatic build(input int t, output bit legal);
        int L, n;
        frm.delete();
        legal = 1'b0;
        if (t <= 5) begin
            L = $urandom_range(1, 12);
            frm.push_back({1'b0, 8'(L)});
            for (int i = 1; i <= L; i++) frm.push_back({(i == L), 8'($urandom)});
            legal = 1'b1;
        end else if (t == 6) begin
            L = $urandom_range(2, 12);
            n = $urandom_range(0, L - 1);
            frm.push_back({(n == 0), 8'(L)});
            for (int i = 1; i <= n; i++) frm.push_back({(i == n), 8'($urandom)});
        end else if (t == 7) begin
            L = $urandom_range(1, 10);
            n = L + $urandom_range(1, 3);
            frm.push_back({1'b0, 8'(L)});
            for (int i = 1; i <= n; i++) frm.push_back({(i == n), 8'($urandom)});
        end else if (t == 8) begin
            n = $urandom_range(0, 2);
            frm.push_back({(n == 0), 8'h00});
            for (int i = 1; i <= n; i++) frm.push_back({(i == n), 8'($urandom)});
        end else begin
            frm.push_back({1'b1, 8'($urandom_range(1, 255))});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_tready"}, {31'd0, s_tready}, 32'd0);
        chk({tag, "_m_tvalid"}, {31'd0, m_tvalid}, 32'd0);
        chk({tag, "_m_tdata"}, {24'd0, m_tdata}, 32'd0);
        chk({tag, "_m_tlast"}, {31'd0, m_tlast}, 32'd0);
        chk({tag, "_pulses"}, {30'd0, p_commit, p_drop}, 32'd0);
        chk({tag, "_counts"}, {c_commit, c_drop}, 32'd0);
    endtask

    initial begin
        bit legal;
        int n;
        logic [7:0] b[$];

        rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        cfg_flush = 1'b0; m_tready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("tready_after_reset", {31'd0, s_tready}, 32'd1);
        idle(2);

        // Basic frame with latency check
        b = '{8'h03, 8'h01, 8'hAA, 8'hBB};
        set_frm(b, 3);
        expect_frm();
        send_frm(0);
        chk("latency_1cyc_idle", {31'd0, m_tvalid}, 32'd0);
        idle(1);
        chk("latency_2cyc_valid", {31'd0, m_tvalid}, 32'd1);
        drain();
        chk("commit_pulses_basic", cnt_commit, exp_commit);

        // Short frame then legal frame on the rolled-back pointer
        b = '{8'h03, 8'h01, 8'hAA};
        set_frm(b, 2);
        exp_drop++;
        send_frm(0);
        b = '{8'h01, 8'h42};
        set_frm(b, 1);
        expect_frm();
        send_frm(0);
        drain();
        chk("drop_pulses_short", cnt_drop, exp_drop);

        // Long frame then legal frame
        b = '{8'h02, 8'h01, 8'hAA, 8'hBB};
        set_frm(b, 3);
        exp_drop++;
        send_frm(0);
        b = '{8'h01, 8'h07};
        set_frm(b, 1);
        expect_frm();
        send_frm(0);
        drain();
        chk("drop_pulses_long", cnt_drop, exp_drop);

        // Overflow with a stalled output
        rmode = 0;
        idle(2);
        b = '{8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        set_frm(b, 9);
        expect_frm();
        send_frm(0);
        b = '{8'h09, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        set_frm(b, 9);
        exp_drop++;
        send_frm(0);
        idle(3);
        chk("drop_pulses_overflow", cnt_drop, exp_drop);
        rmode = 1;
        drain();

        // Flush mid-frame, beat in flush cycle discarded
        b = '{8'h05, 8'h11, 8'h22};
        set_frm(b, -1);
        send_frm(0);
        cfg_flush = 1'b1; s_tdata = 8'h33; s_tvalid = 1'b1;
        @(posedge clk); #1;
        cfg_flush = 1'b0; s_tvalid = 1'b0;
        b = '{8'h01, 8'h05};
        set_frm(b, 1);
        expect_frm();
        send_frm(0);
        drain();
        chk("drop_pulses_flush", cnt_drop, exp_drop);
        chk("commit_pulses_flush", cnt_commit, exp_commit);

        // Randomized frames with random output backpressure
        rmode = 2;
        for (int k = 0; k < 120; k++) begin
            build($urandom_range(9), legal);
            n = 0;
            while (sb.size() + frm.size() > DEPTH - 1 && n < 2000) begin
                idle(1);
                n++;
            end
            if (n >= 2000) begin
                total++;
                bad++;
                $display("FAIL space_timeout occupancy=%0d required<=%0d", sb.size(), DEPTH - 1 - frm.size());
                sb.delete();
            end
            if (legal) expect_frm();
            else exp_drop++;
            send_frm(1);
            if ($urandom_range(4) == 0) idle($urandom_range(1, 3));
        end
        rmode = 1;
        drain();
        chk("commit_pulses_random", cnt_commit, exp_commit);
        chk("drop_pulses_random", cnt_drop, exp_drop);

        // Reset mid-frame discards buffered and partial frames
        rmode = 0;
        idle(1);
        b = '{8'h01, 8'h33};
        set_frm(b, 1);
        send_frm(0);
        b = '{8'h04, 8'h01, 8'h02};
        set_frm(b, -1);
        send_frm(0);
        idle(2);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_commit = 0; exp_drop = 0; cnt_commit = 0; cnt_drop = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        rmode = 1;
        @(posedge clk); #1;
        chk("tready_after_midreset", {31'd0, s_tready}, 32'd1);

        // Three legal and two malformed frames for the statistics
        for (int k = 0; k < 5; k++) begin
            build((k == 1) ? 6 : (k == 3) ? 9 : 0, legal);
            if (legal) expect_frm();
            else exp_drop++;
            send_frm(0);
        end
        drain();
        chk("commit_pulses_final", cnt_commit, exp_commit);
        chk("drop_pulses_final", cnt_drop, exp_drop);
`ifdef FRAME_STORE_STATS_EN
        chk("stat_committed_count", {16'd0, c_commit}, exp_commit);
        chk("stat_dropped_count", {16'd0, c_drop}, exp_drop);
`else
        chk("stat_committed_count", {16'd0, c_commit}, 32'd0);
        chk("stat_dropped_count", {16'd0, c_drop}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
